frame_stream_gen: RTL

FRAME_STREAM_GEN -- requirements
Module: frame_stream_gen

---
 rtl/frame_stream_pkg.sv | 29 ++
 rtl/frame_stream_lfsr16.sv | 27 ++
 rtl/frame_stream_gen.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/frame_stream_pkg.sv
// Shared definitions for the frame stream generator.
//   mode_e     : test pattern selector (RAMP, LFSR, CONST, reserved->RAMP)
//   state_e    : generator FSM encoding
//   LFSR_TAPS  : Galois feedback mask for taps 16,14,13,11 (right-shifting form)
//   lfsr_next  : one LFSR step
package frame_stream_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_RESET = 16'h0001;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/frame_stream_lfsr16.sv
// 16-bit Galois LFSR used for the LFSR pattern and stall gap generation.
//   clk, reset : clock, synchronous active-high reset (state -> 16'h0001)
//   load, seed : load seed (a zero seed is replaced by 16'h0001 to avoid lock-up)
//   step       : advance one step (ignored while load is high)
//   state      : current LFSR contents
module lfsr16
    import frame_stream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_RESET;
        end else if (load) begin
            state <= (seed == 16'h0000) ? LFSR_RESET : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/frame_stream_gen.sv
// Frame stream generator: emits width x height beats of a test pattern on a
// valid/ready stream, with optional pseudo-random valid gaps.
//   clk, reset           : clock, synchronous active-high reset
//   start                : frame start request (honoured in IDLE only)
//   cfg_width/cfg_height : frame columns / rows, latched at start
//   cfg_mode             : 0 RAMP, 1 LFSR, 2 CONST, 3 treated as RAMP
//   cfg_stall_en         : enable pseudo-random gaps between beats
//   cfg_seed             : LFSR seed and CONST value
//   data_out             : CHANNELS samples, channel c at [c*DATA_W +: DATA_W]
//   valid, ready         : beat handshake
//   last, eol            : final beat of frame / of row
//   busy, done           : frame in progress / one-cycle completion pulse
module frame_stream_gen
    import frame_stream_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int DIM_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DIM_W-1:0]             cfg_width,
    input  logic [DIM_W-1:0]             cfg_height,
    input  logic [1:0]                   cfg_mode,
    input  logic                         cfg_stall_en,
    input  logic [15:0]                  cfg_seed,
    output logic [CHANNELS*DATA_W-1:0]   data_out,
    output logic                         valid,
    output logic                         last,
    output logic                         eol,
    input  logic                         ready,
    output logic                         busy,
    output logic                         done
);

    // Ramp arithmetic wide enough for both the column counter and the sample.
    localparam int RW = (DIM_W > DATA_W) ? DIM_W : DATA_W;

    state_e              state, state_nxt;
    logic [DIM_W-1:0]    width_q, height_q, x_q, y_q;
    logic [RW-1:0]       offset_q;      // running y*width
    mode_e               mode_q;
    logic                stall_en_q;
    logic [DATA_W-1:0]   const_q;
    logic [4:0]          stall_cnt_q;
    logic [15:0]         lfsr_state;

    logic dims_zero, at_eol, at_last, stall_hit, xfer, take_stall, lfsr_load;

    assign dims_zero  = (width_q == '0) || (height_q == '0);
    assign at_eol     = (x_q == width_q - DIM_W'(1));
    assign at_last    = at_eol && (y_q == height_q - DIM_W'(1));
    assign stall_hit  = stall_en_q && lfsr_state[0];
    assign xfer       = valid && ready;
    assign take_stall = xfer && !at_last && stall_hit;
    assign lfsr_load  = (state == ST_IDLE) && start;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .seed  (cfg_seed),
        .step  (xfer),
        .state (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero-sized frame spends one cycle in RUN (valid held low) so the
    // size check works on the latched dimensions rather than the live inputs.
    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        eol       = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (dims_zero) begin
                    state_nxt = ST_DONE;
                end else begin
                    valid = 1'b1;
                    eol   = at_eol;
                    last  = at_last;
                    if (ready) begin
                        if (at_last)        state_nxt = ST_DONE;
                        else if (stall_hit) state_nxt = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                busy = 1'b1;
                if (stall_cnt_q == '0) state_nxt = ST_RUN;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            width_q     <= '0;
            height_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            offset_q    <= '0;
            mode_q      <= MODE_RAMP;
            stall_en_q  <= 1'b0;
            const_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (lfsr_load) begin
                width_q    <= cfg_width;
                height_q   <= cfg_height;
                mode_q     <= mode_e'(cfg_mode);
                stall_en_q <= cfg_stall_en;
                const_q    <= DATA_W'(cfg_seed);
                x_q        <= '0;
                y_q        <= '0;
                offset_q   <= '0;
            end
            if (xfer) begin
                if (at_eol) begin
                    x_q      <= '0;
                    y_q      <= y_q + DIM_W'(1);
                    offset_q <= offset_q + RW'(width_q);
                end else begin
                    x_q <= x_q + DIM_W'(1);
                end
            end
            // STALL lasts stall_cnt+1 cycles: it counts down to zero, then exits.
            if (take_stall) begin
                stall_cnt_q <= lfsr_state[5:1];
            end else if (state == ST_STALL && stall_cnt_q != '0) begin
                stall_cnt_q <= stall_cnt_q - 5'd1;
            end
        end
    end

    logic [RW-1:0]     ramp;
    logic [15:0]       rot;
    logic [DATA_W-1:0] chan;

    always_comb begin
        data_out = '0;
        ramp     = '0;
        rot      = '0;
        chan     = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            ramp = RW'(x_q) + offset_q + RW'(c);
            rot  = (lfsr_state << (4 * c)) | (lfsr_state >> (16 - 4 * c));
            case (mode_q)
                MODE_LFSR:  chan = DATA_W'(rot);
                MODE_CONST: chan = const_q;
                default:    chan = DATA_W'(ramp);
            endcase
            if (valid) data_out[c*DATA_W +: DATA_W] = chan;
        end
    end

endmodule
